nibble_serial_adder: RTL

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nsa_pkg.sv | 12 +
 rtl/nibble_serial_adder_cla.sv | 28 ++
 rtl/nibble_serial_adder.sv | 123 ++++++++++++
 3 files changed

// File: rtl/nsa_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and slice width.
package nsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int NIBBLE_W = 4;

endpackage

// File: rtl/nibble_serial_adder_cla.sv
// 4-bit carry look-ahead adder, the single arithmetic slice reused by the serial adder.
module carry_look_ahead_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate terms with fully expanded look-ahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    sum  = p ^ c[3:0];
    cout = c[4];
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle adder: one 4-bit slice per cycle through a shared look-ahead adder,
// with a valid/ready handshake on both the operand and result sides.
module nibble_serial_adder
  import nsa_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NIBBLE_W*NIBBLES-1:0] a,
  input  logic [NIBBLE_W*NIBBLES-1:0] b,
  input  logic                    cin,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NIBBLE_W*NIBBLES-1:0] sum,
  output logic                    cout,
  output logic                    ovf
);

  localparam int W     = NIBBLE_W * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t                state;
  logic [IDX_W-1:0]      idx;
  logic                  carry;
  logic [W-1:0]          a_q;
  logic [W-1:0]          b_q;
  logic [W-1:0]          sum_q;
  logic                  cout_q;
  logic                  ovf_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic [NIBBLE_W-1:0]   slice_a;
  logic [NIBBLE_W-1:0]   slice_b;
  logic [NIBBLE_W-1:0]   slice_sum;
  logic                  slice_cout;

  // Pick the current nibble of each latched operand for the shared slice adder.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        slice_a = a_q[i*NIBBLE_W +: NIBBLE_W];
        slice_b = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  carry_look_ahead_adder u_cla (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry),
    .sum (slice_sum),
    .cout(slice_cout)
  );

  // Control FSM and datapath registers; handshake flags are registered alongside the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      carry       <= 1'b0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            carry      <= cin;
            idx        <= '0;
            state      <= ADD;
            in_ready_q <= 1'b0;
          end
        end
        ADD: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IDX_W'(i)) begin
              sum_q[i*NIBBLE_W +: NIBBLE_W] <= slice_sum;
            end
          end
          carry <= slice_cout;
          idx   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            state       <= DONE;
            out_valid_q <= 1'b1;
            cout_q      <= slice_cout;
            ovf_q       <= (a_q[W-1] == b_q[W-1]) && (slice_sum[NIBBLE_W-1] != a_q[W-1]);
          end
        end
        DONE: begin
          if (out_ready) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          idx         <= '0;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
